// File: rtl/zero_elim_pkg.sv
// Shared types and default sizing for the zero-elimination scheduler.
// Holds the FSM state encoding and default width constants.
package zero_elim_pkg;

    localparam int DEF_BIT_WIDTH  = 16;
    localparam int DEF_NUM_INPUTS = 16;
    localparam int DEF_SEL_WIDTH  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_16_to_1_v2.sv
// Brick entry selector: returns entry i_sel of a packed brick.
// Ports: i_data (packed brick), i_sel (entry index), o_data (entry).
module mux_16_to_1_v2
    import zero_elim_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
    input  logic [NUM_INPUTS*BIT_WIDTH-1:0] i_data,
    input  logic [SEL_WIDTH-1:0]            i_sel,
    output logic [BIT_WIDTH-1:0]            o_data
);

    always_comb begin
        o_data = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (i_sel == SEL_WIDTH'(k)) begin
                o_data = i_data[k*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

endmodule

// File: rtl/zero_elim_scheduler.sv
// Zero-elimination scheduler: accepts a brick, streams its non-zero
// entries lowest offset first, one beat per cycle with valid/ready.
// Ports: clk, rst (sync, active-high); i_valid/o_ready/i_brick in;
// o_valid/i_ready/o_data/o_offset/o_last/o_empty out.
// Build option: define ZE_EMPTY_MARKER_EN to emit a marker beat
// (o_empty = 1) for an all-zero brick instead of dropping it.
module zero_elim_scheduler
    import zero_elim_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    input  logic [NUM_INPUTS*BIT_WIDTH-1:0] i_brick,
    output logic                            o_ready,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [BIT_WIDTH-1:0]            o_data,
    output logic [SEL_WIDTH-1:0]            o_offset,
    output logic                            o_last,
    output logic                            o_empty
);

    state_t                          state_q;
    state_t                          state_d;
    logic [NUM_INPUTS*BIT_WIDTH-1:0] brick_q;
    logic [NUM_INPUTS-1:0]           mask_q;
    logic [NUM_INPUTS-1:0]           mask_in;
    logic [SEL_WIDTH-1:0]            sel;
    logic [BIT_WIDTH-1:0]            mux_data;
    logic                            accept;
    logic                            beat;
    logic                            only_one;
    logic                            start_ok;
    logic                            empty_q;

    // Bitwise zero test, so a lone sign bit still counts as non-zero.
    always_comb begin
        mask_in = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            mask_in[k] = |i_brick[k*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    // Lowest set bit wins: scan high to low so the last hit sticks.
    always_comb begin
        sel = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (mask_q[k]) begin
                sel = SEL_WIDTH'(k);
            end
        end
    end

    assign only_one = (mask_q != '0) &&
                      ((mask_q & (mask_q - NUM_INPUTS'(1))) == '0);

    // Kept apart from the FSM block so o_ready does not feed back.
    assign accept = i_valid && (state_q == IDLE) && !rst;
    assign beat   = o_valid && i_ready;

`ifdef ZE_EMPTY_MARKER_EN
    assign start_ok = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            empty_q <= 1'b0;
        end else if (accept) begin
            empty_q <= (mask_in == '0);
        end else if (beat && o_last) begin
            empty_q <= 1'b0;
        end
    end
`else
    assign start_ok = |mask_in;
    assign empty_q  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        o_last   = 1'b0;
        o_empty  = 1'b0;
        o_offset = '0;
        unique case (state_q)
            IDLE: begin
                o_ready = !rst;
                if (accept && start_ok) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                o_valid  = !rst;
                o_offset = rst ? '0 : sel;
                o_last   = !rst && (only_one || empty_q);
                o_empty  = !rst && empty_q;
                if (o_valid && i_ready && o_last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // x & (x - 1) drops the lowest set bit, i.e. the one at o_offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            brick_q <= '0;
            mask_q  <= '0;
        end else if (accept) begin
            brick_q <= i_brick;
            mask_q  <= mask_in;
        end else if (beat) begin
            mask_q  <= mask_q & (mask_q - NUM_INPUTS'(1));
        end
    end

    mux_16_to_1_v2 #(
        .BIT_WIDTH  (BIT_WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_mux (
        .i_data (brick_q),
        .i_sel  (o_offset),
        .o_data (mux_data)
    );

    assign o_data = o_valid ? mux_data : '0;

endmodule

// File: doc/zero_elim_scheduler.md
ZERO_ELIM_SCHEDULER -- requirements
Module: zero_elim_scheduler

Interface
REQ-001 Parameter BIT_WIDTH, default 16: width of one neuron value.
REQ-002 Parameter NUM_INPUTS, default 16: neuron values per brick.
REQ-003 Parameter SEL_WIDTH, default 4: mux select width, equal to log2(NUM_INPUTS).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_valid  input  1  brick offered.
REQ-007 i_brick  input  NUM_INPUTS*BIT_WIDTH  packed brick, entry k at bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH].
REQ-008 o_ready  output  1  scheduler can accept a brick.
REQ-009 o_valid  output  1  output beat valid.
REQ-010 i_ready  input  1  downstream accepts beat.
REQ-011 o_data  output  BIT_WIDTH  selected non-zero value.
REQ-012 o_offset  output  SEL_WIDTH  index of o_data within the brick (also the mux select).
REQ-013 o_last  output  1  final beat of the current brick.
REQ-014 o_empty  output  1  current beat is an all-zero marker (see Configuration).

Function
REQ-015 The brick transfer SHALL occur on a cycle with i_valid && o_ready; the brick is then registered and a NUM_INPUTS-bit non-zero mask is computed, bit k = (entry k != 0).
REQ-016 FSM states SHALL be IDLE and EMIT; o_ready = 1 only in IDLE.
REQ-017 IDLE -> EMIT on a brick transfer with a non-zero mask; IDLE held otherwise.
REQ-018 In EMIT, o_valid = 1, o_offset = index of the lowest set bit of the remaining mask, and o_data = registered entry o_offset.
REQ-019 On an EMIT beat with i_ready = 1, the bit at o_offset SHALL be cleared; if it was the only bit left, o_last = 1 on that beat and the next state is IDLE.
REQ-020 First beat latency: o_valid SHALL rise the cycle after the brick transfer; one beat per cycle while i_ready = 1.
REQ-021 Stall: while o_valid && !i_ready, o_data, o_offset and o_last SHALL hold stable.
REQ-022 A brick with M non-zero entries SHALL produce exactly M beats, in ascending offset order; zero entries are never emitted.
REQ-023 i_brick is ignored when o_ready = 0; no brick is accepted on the cycle of the o_last handshake (one IDLE bubble between bricks).
REQ-024 Values are compared to zero bitwise; the value with only the sign bit set is non-zero.

Reset
REQ-025 With rst = 1: state = IDLE, mask = 0, o_valid = 0, o_last = 0, o_empty = 0, o_offset = 0, o_data = 0, o_ready = 0 during reset and 1 the first cycle after.
REQ-026 Reset during EMIT SHALL discard the remaining beats of the brick with no further output.

Configuration
REQ-027 Macro ZE_EMPTY_MARKER_EN: when defined, an all-zero brick SHALL cause IDLE -> EMIT and one beat with o_data = 0, o_offset = 0, o_last = 1, o_empty = 1.
REQ-028 Without ZE_EMPTY_MARKER_EN, an all-zero brick SHALL be accepted and silently dropped (state stays IDLE) and o_empty is tied 0.

Structure
REQ-029 Package zero_elim_pkg SHALL hold the FSM state encoding and the default BIT_WIDTH/NUM_INPUTS/SEL_WIDTH constants.
REQ-030 Data selection SHALL instantiate one mux_16_to_1_v2 sub-module driven by o_offset; the priority encoder stays inline.

Verification
REQ-031 Brick with non-zero entries only at offsets 2 (0x0005), 9 (0x8000), 15 (0x0001), i_ready = 1 -> beats (2,0x0005),(9,0x8000),(15,0x0001,o_last) on consecutive cycles starting the cycle after transfer.
REQ-032 Same brick, i_ready held 0 for 3 cycles on beat 2 -> offset 9 and data 0x8000 held stable for all 3 cycles, then the sequence resumes.
REQ-033 All 16 entries non-zero -> 16 beats, offsets 0..15, o_last only on offset 15, o_ready = 0 throughout.
REQ-034 All-zero brick -> with ZE_EMPTY_MARKER_EN: one beat, o_empty = 1, o_last = 1; without it: no beat and o_ready stays 1.
REQ-035 rst asserted after the 2nd of 5 beats -> o_valid = 0 the next cycle, no further beats, o_ready = 1 after release.
REQ-036 i_valid held high with two bricks back-to-back -> the second brick is accepted exactly one cycle after the first brick's o_last handshake.
